ps2_msx_keymatrix: RTL and testbench

Converts a PS/2 keyboard byte stream into the 11-row × 8-column MSX keyboard matrix and returns the selected row's column byte to the PPI. It sits directly upstream of the PPI port B input: PPI port C bits 3:0 drive `ROW`, and `COLS` drives PPI `PB`. Scancode-to-matrix translation comes from an external combinational lookup table so that keyboard layouts can be swapped without touching this block.

---
 rtl/ps2_msx_keymatrix.sv | 221 ++++++++++++++++++++++
 tb/tb_ps2_msx_keymatrix.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_msx_keymatrix.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_msx_keymatrix
//  Purpose  : PS/2 keyboard receiver and scancode decoder that maintains the
//             11 x 8 MSX keyboard matrix and returns the row selected by the
//             PPI as an active-low column byte.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_msx_keymatrix #(
    parameter int TIMEOUT = 8191,
    parameter int TW      = 13
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic [3:0] ROW,
    output logic [7:0] COLS,
    output logic [8:0] MAP_CODE,
    input  logic       MAP_VALID,
    input  logic [3:0] MAP_ROW,
    input  logic [2:0] MAP_BIT,
    output logic       KEY_STB,
    output logic       ERR
);

    localparam logic [7:0]    C_EXT     = 8'hE0;
    localparam logic [7:0]    C_BRK     = 8'hF0;
    localparam logic [7:0]    C_PAUSE   = 8'hE1;
    localparam logic [2:0]    C_SKIPLEN = 3'd7;
    localparam logic [3:0]    C_MAXROW  = 4'd10;
    localparam logic [TW-1:0] C_TMO     = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // Synchronizer and edge-detect flops; line idles high so reset to 1
    logic ps2c_meta_q, ps2c_sync_q, ps2c_prev_q;
    logic ps2d_meta_q, ps2d_sync_q;
    logic w_fall;

    // Receiver state
    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          rx_stb_d, rx_stb_q;
    logic          rx_err_d, err_q;
    logic          tmo_d;

    // Decoder state and matrix
    logic          ext_q, brk_q;
    logic [2:0]    skip_q;
    logic [8:0]    map_code_q;
    logic          key_stb_q;
    logic [7:0]    mat_q [0:10];
    logic [7:0]    cols_q;
    logic          w_is_lookup;

    // Two-stage synchronizers plus a history flop for falling-edge detection
    always_ff @(posedge CLK) begin
        if (RST) begin
            ps2c_meta_q <= 1'b1;
            ps2c_sync_q <= 1'b1;
            ps2c_prev_q <= 1'b1;
            ps2d_meta_q <= 1'b1;
            ps2d_sync_q <= 1'b1;
        end else begin
            ps2c_meta_q <= PS2_CLK;
            ps2c_sync_q <= ps2c_meta_q;
            ps2c_prev_q <= ps2c_sync_q;
            ps2d_meta_q <= PS2_DAT;
            ps2d_sync_q <= ps2d_meta_q;
        end
    end

    assign w_fall = ps2c_prev_q & ~ps2c_sync_q;

    // Receiver registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            shift_q  <= 8'h00;
            bitcnt_q <= 3'd0;
            par_q    <= 1'b0;
            tcnt_q   <= '0;
            rx_stb_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            par_q    <= par_d;
            tcnt_q   <= tcnt_d;
            rx_stb_q <= rx_stb_d;
            err_q    <= rx_err_d;
        end
    end

    // Frame receiver next-state: bit sampling, frame check and inactivity timeout
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        par_d    = par_q;
        tcnt_d   = tcnt_q;
        rx_stb_d = 1'b0;
        rx_err_d = 1'b0;
        tmo_d    = 1'b0;

        if (state_q == S_IDLE || w_fall) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end

        if (state_q != S_IDLE && !w_fall && tcnt_q == C_TMO) begin
            // Stalled partial frame: drop it
            state_d  = S_IDLE;
            tcnt_d   = '0;
            rx_err_d = 1'b1;
            tmo_d    = 1'b1;
        end else if (w_fall) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!ps2d_sync_q) begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d  = {ps2d_sync_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_d   = ps2d_sync_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    // Data plus parity must be odd and the stop bit high
                    if ((^{shift_q, par_q}) && ps2d_sync_q) begin
                        rx_stb_d = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign w_is_lookup = (shift_q != C_EXT) && (shift_q != C_BRK) && (shift_q != C_PAUSE);

    // Scancode decoder: prefix flags, pause skipping and matrix updates
    always_ff @(posedge CLK) begin
        if (RST) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            skip_q     <= 3'd0;
            map_code_q <= 9'h000;
            key_stb_q  <= 1'b0;
            for (int r = 0; r < 11; r++) begin
                mat_q[r] <= 8'hFF;
            end
        end else begin
            key_stb_q <= 1'b0;
            // Present the lookup address during the byte strobe cycle
            if (rx_stb_d && skip_q == 3'd0 && w_is_lookup) begin
                map_code_q <= {ext_q, shift_q};
            end
            if (tmo_d) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (rx_stb_q) begin
                if (skip_q != 3'd0) begin
                    skip_q <= skip_q - 3'd1;
                end else if (shift_q == C_EXT) begin
                    ext_q <= 1'b1;
                end else if (shift_q == C_BRK) begin
                    brk_q <= 1'b1;
                end else if (shift_q == C_PAUSE) begin
                    skip_q <= C_SKIPLEN;
                end else begin
                    if (MAP_VALID && MAP_ROW <= C_MAXROW) begin
                        mat_q[MAP_ROW][MAP_BIT] <= brk_q;
                        key_stb_q               <= 1'b1;
                    end
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end
        end
    end

    // Registered row read-back; rows beyond the matrix read as released
    always_ff @(posedge CLK) begin
        if (RST) begin
            cols_q <= 8'hFF;
        end else if (ROW <= C_MAXROW) begin
            cols_q <= mat_q[ROW];
        end else begin
            cols_q <= 8'hFF;
        end
    end

    assign COLS     = cols_q;
    assign MAP_CODE = map_code_q;
    assign KEY_STB  = key_stb_q;
    assign ERR      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_msx_keymatrix.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ps2_msx_keymatrix
//  Purpose  : Self-checking bench for ps2_msx_keymatrix with directed and
//             randomized PS/2 traffic against a behavioural key-matrix model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_msx_keymatrix;

    localparam int TIMEOUT = 8191;
    localparam int HALF    = 20;

    logic       CLK = 1'b0;
    logic       RST;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [3:0] ROW;
    logic [7:0] COLS;
    logic [8:0] MAP_CODE;
    logic       MAP_VALID;
    logic [3:0] MAP_ROW;
    logic [2:0] MAP_BIT;
    logic       KEY_STB;
    logic       ERR;

    int checks = 0;
    int errors = 0;
    int n_stb  = 0;
    int n_err  = 0;

    // Reference model state
    logic [7:0] mm [0:10];
    bit         m_ext, m_brk;
    int         m_skip;
    logic [8:0] m_code;
    int         e_stb, e_err;

    always #5 CLK = ~CLK;

    ps2_msx_keymatrix #(.TIMEOUT(TIMEOUT), .TW(13)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .PS2_CLK  (PS2_CLK),
        .PS2_DAT  (PS2_DAT),
        .ROW      (ROW),
        .COLS     (COLS),
        .MAP_CODE (MAP_CODE),
        .MAP_VALID(MAP_VALID),
        .MAP_ROW  (MAP_ROW),
        .MAP_BIT  (MAP_BIT),
        .KEY_STB  (KEY_STB),
        .ERR      (ERR)
    );

    // External layout table: {valid, row, bit}
    function automatic logic [7:0] lookup(input logic [8:0] c);
        case (c)
            9'h01C:  return {1'b1, 4'd2, 3'd6};
            9'h175:  return {1'b1, 4'd8, 3'd5};
            default: return {(c[1:0] != 2'b11), c[7:4], c[2:0] ^ {c[8], 2'b00}};
        endcase
    endfunction

    always_comb {MAP_VALID, MAP_ROW, MAP_BIT} = lookup(MAP_CODE);

    // Pulse counters sampled away from the active edge
    always @(negedge CLK) begin
        if (KEY_STB === 1'b1) n_stb++;
        if (ERR === 1'b1)     n_err++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 11; r++) mm[r] = 8'hFF;
        m_ext  = 0;
        m_brk  = 0;
        m_skip = 0;
        m_code = 9'h000;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] lk;
        if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else begin
            m_code = {m_ext, b};
            lk = lookup(m_code);
            if (lk[7] && int'(lk[6:3]) <= 10) begin
                mm[lk[6:3]][lk[2:0]] = m_brk;
                e_stb++;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic ps2_bit(input logic d);
        @(negedge CLK);
        PS2_DAT = d;
        repeat (HALF) @(negedge CLK);
        PS2_CLK = 1'b0;
        repeat (HALF) @(negedge CLK);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        repeat (10) @(negedge CLK);
    endtask

    task automatic do_byte(input logic [7:0] b);
        model_byte(b);
        send_frame(b, 1'b0);
        check("key_stb_count", 16'(n_stb), 16'(e_stb));
        check("err_count", 16'(n_err), 16'(e_err));
        check("map_code", {7'd0, MAP_CODE}, {7'd0, m_code});
    endtask

    task automatic read_row(input int r, input string tag);
        logic [7:0] exp;
        ROW = 4'(r);
        @(negedge CLK);
        exp = (r <= 10) ? mm[r] : 8'hFF;
        check(tag, {8'd0, COLS}, {8'd0, exp});
    endtask

    task automatic check_all(input string tag);
        for (int r = 0; r < 16; r++) read_row(r, tag);
    endtask

    initial begin
        logic [7:0] b;
        int         stb0, err0;

        RST = 1'b1; PS2_CLK = 1'b1; PS2_DAT = 1'b1; ROW = 4'd0;
        e_stb = 0; e_err = 0;
        model_reset();
        repeat (3) @(negedge CLK);
        check("reset_cols", {8'd0, COLS}, 16'h00FF);
        check("reset_keystb", {15'd0, KEY_STB}, 16'd0);
        check("reset_err", {15'd0, ERR}, 16'd0);
        check("reset_mapcode", {7'd0, MAP_CODE}, 16'd0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // Press and release
        do_byte(8'h1C);
        ROW = 4'd2; @(negedge CLK);
        check("press_1c", {8'd0, COLS}, 16'h00BF);
        check("press_1c_stb", 16'(n_stb), 16'd1);
        do_byte(8'hF0); do_byte(8'h1C);
        read_row(2, "release_1c");
        check("release_1c_const", {8'd0, COLS}, 16'h00FF);

        // Extended key
        do_byte(8'hE0); do_byte(8'h75);
        check("ext_mapcode", {7'd0, MAP_CODE}, 16'h0175);
        ROW = 4'd8; @(negedge CLK);
        check("ext_press", {8'd0, COLS}, 16'h00DF);
        do_byte(8'hE0); do_byte(8'hF0); do_byte(8'h75);
        read_row(8, "ext_release");

        // Parity error, then a good frame
        send_frame(8'h1C, 1'b1);
        e_err++;
        check("parity_err", 16'(n_err), 16'(e_err));
        read_row(2, "parity_row2");
        do_byte(8'h1C);
        read_row(2, "after_parity");
        do_byte(8'hF0); do_byte(8'h1C);

        // Timeout on a partial frame
        err0 = n_err;
        for (int i = 0; i < 5; i++) ps2_bit(i[0]);
        repeat (TIMEOUT + 10) @(negedge CLK);
        e_err++;
        m_ext = 0; m_brk = 0;
        check("timeout_err", 16'(n_err - err0), 16'd1);
        do_byte(8'h1C);
        ROW = 4'd2; @(negedge CLK);
        check("after_timeout", {8'd0, COLS}, 16'h00BF);

        // Pause sequence is swallowed
        stb0 = n_stb;
        do_byte(8'hE1); do_byte(8'h14); do_byte(8'h77); do_byte(8'hE1);
        do_byte(8'hF0); do_byte(8'h14); do_byte(8'hF0); do_byte(8'h77);
        check("pause_no_stb", 16'(n_stb - stb0), 16'd0);
        do_byte(8'h1C);
        check("after_pause_stb", 16'(n_stb - stb0), 16'd1);
        check_all("after_pause_scan");

        // Randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 15)      b = 8'hE0;
            else if (sel < 30) b = 8'hF0;
            else if (sel < 33) b = 8'hE1;
            else               b = 8'($urandom);
            if ($urandom_range(0, 99) < 8) begin
                send_frame(b, 1'b1);
                e_err++;
                check("rand_bad_err", 16'(n_err), 16'(e_err));
            end else begin
                do_byte(b);
            end
            read_row($urandom_range(0, 15), "rand_row");
            if (it % 15 == 14) check_all("rand_scan");
        end

        // Reset with keys held
        do_byte(8'h1C);
        do_byte(8'hE0); do_byte(8'h75);
        err0 = n_err;
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK); RST = 1'b0;
        model_reset();
        check_all("post_reset_scan");
        check("post_reset_err", 16'(n_err), 16'(err0));
        check("post_reset_mapcode", {7'd0, MAP_CODE}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
